// File: rtl/bcd_operand_entry.sv
// Two-operand BCD digit entry: synchronized/debounced Enter, digit shift-in FSM, Valid in DONE.
// Optional auto-repeat while Enter is held: define BCD_ENTRY_REPEAT_EN.
module bcd_operand_entry #(
    parameter int DIGITS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                         CLOCK_50,
    input  logic                         Reset,
    input  logic [3:0]                   Digit,
    input  logic                         Enter,
    input  logic                         Clear,
    output logic [4*DIGITS-1:0]          OpA,
    output logic [4*DIGITS-1:0]          OpB,
    output logic                         Valid,
    output logic [1:0]                   Phase,
    output logic [$clog2(DIGITS+1)-1:0]  DigitCount,
    output logic                         BadDigit
);
    localparam int OW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DIGITS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("bcd_operand_entry: DIGITS, DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {ENTER_A = 2'd0, ENTER_B = 2'd1, DONE = 2'd2} state_t;

    state_t          state, state_n;
    logic [OW-1:0]   opa_n, opb_n;
    logic [CW-1:0]   cnt_n;
    logic            bad_n;

    logic            sync_p0, sync_p1;
    logic [DW-1:0]   deb_cnt;
    logic            deb_lvl, deb_lvl_q;
    logic [1:0]      fill;
    logic            armed;
    logic            rise;
    logic            press;

    // Stage boundary: two-flop synchronizer, then debounce. "armed" stays low after
    // Reset until the synchronized button has been seen released, so a button held
    // through Reset cannot fire.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            deb_cnt   <= '0;
            deb_lvl   <= 1'b0;
            deb_lvl_q <= 1'b0;
            fill      <= 2'd0;
            armed     <= 1'b0;
        end else begin
            sync_p0   <= Enter;
            sync_p1   <= sync_p0;
            deb_lvl_q <= deb_lvl;
            if (sync_p1 == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_lvl <= sync_p1;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
            if (!fill[1]) fill <= fill + 2'd1;
            if (fill[1] && !sync_p1) armed <= 1'b1;
        end
    end

    assign rise = deb_lvl && !deb_lvl_q && armed;

`ifdef BCD_ENTRY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rep_cnt;
    logic          rep_fire;

    assign rep_fire = (rep_cnt == RW'(REPEAT_CYCLES)) && (state != DONE);

    always_ff @(posedge CLOCK_50) begin
        if (Reset || Clear || !deb_lvl || !armed || state == DONE) begin
            rep_cnt <= '0;
        end else if (rep_fire) begin
            rep_cnt <= RW'(1);
        end else begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end

    assign press = rise || rep_fire;
`else
    assign press = rise;
`endif

    // Stage boundary: entry FSM next-state and operand shift-in
    always_comb begin
        state_n = state;
        opa_n   = OpA;
        opb_n   = OpB;
        cnt_n   = DigitCount;
        bad_n   = BadDigit;
        if (Clear) begin
            state_n = ENTER_A;
            opa_n   = '0;
            opb_n   = '0;
            cnt_n   = '0;
            bad_n   = 1'b0;
        end else if (press) begin
            case (state)
                ENTER_A, ENTER_B: begin
                    if (Digit > 4'd9) begin
                        bad_n = 1'b1;
                    end else begin
                        bad_n = 1'b0;
                        if (state == ENTER_A) opa_n = (OpA << 4) | OW'(Digit);
                        else                  opb_n = (OpB << 4) | OW'(Digit);
                        if (DigitCount == CW'(DIGITS - 1)) begin
                            cnt_n   = '0;
                            state_n = (state == ENTER_A) ? ENTER_B : DONE;
                        end else begin
                            cnt_n = DigitCount + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state_n = ENTER_A;
                    opa_n   = '0;
                    opb_n   = '0;
                    cnt_n   = '0;
                    bad_n   = 1'b0;
                end
                default: state_n = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state      <= ENTER_A;
            OpA        <= '0;
            OpB        <= '0;
            DigitCount <= '0;
            BadDigit   <= 1'b0;
        end else begin
            state      <= state_n;
            OpA        <= opa_n;
            OpB        <= opb_n;
            DigitCount <= cnt_n;
            BadDigit   <= bad_n;
        end
    end

    assign Valid = (state == DONE);
    assign Phase = state;

endmodule

// File: doc/bcd_operand_entry.md
Name: bcd_operand_entry

Overview:
Sequential front end that feeds the two-digit BCD adder stage. Collects two multi-digit BCD operands one digit at a time from the digit switches, using a debounced Enter pushbutton. Presents OpA/OpB as packed BCD together with a Valid flag, ready for the downstream adder and hex display stage. Rejects non-BCD digits and flags them.

Parameters:
DIGITS, 2, BCD digits per operand; operand width is 4*DIGITS.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced Enter level changes (10 ms at 50 MHz).
REPEAT_CYCLES, 25000000, hold time between auto-repeat presses; used only when BCD_ENTRY_REPEAT_EN is defined.

Ports:
CLOCK_50  input  1  system clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-high; dominates every other input.
Digit  input  4  candidate digit, from the switches; sampled on an accepted press.
Enter  input  1  raw pushbutton, active-high, asynchronous to CLOCK_50.
Clear  input  1  synchronous, active-high; aborts entry.
OpA  output  4*DIGITS  operand A, packed BCD, most recent digit in [3:0].
OpB  output  4*DIGITS  operand B, same format as OpA.
Valid  output  1  high while both operands are complete (state DONE).
Phase  output  2  current state: 0 ENTER_A, 1 ENTER_B, 2 DONE.
DigitCount  output  $clog2(DIGITS+1)  digits accepted for the current operand.
BadDigit  output  1  sticky flag: last press carried Digit > 9.

Behaviour:
- Reset values: OpA=0, OpB=0, Valid=0, Phase=ENTER_A, DigitCount=0, BadDigit=0. Synchronizer, debounce counter and debounced level all 0.
- Enter input path:
  - Two-flop synchronizer produces Enter_s.
  - Debounce counter increments each cycle Enter_s differs from the debounced level. It clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes Enter_s on that edge and the counter clears.
  - A one-cycle Press pulse fires in the cycle after the debounced level rises. A falling edge produces no pulse.
- Latency: the operand register and outputs update on the edge that ends the Press cycle. Total from the raw Enter rising edge is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Glitches shorter than DEBOUNCE_CYCLES never produce a Press.
- FSM on a Press:
  - ENTER_A, Digit <= 9: OpA <= {OpA[4*DIGITS-5:0], Digit}, DigitCount+1, BadDigit cleared. When DigitCount reaches DIGITS, go to ENTER_B and set DigitCount=0.
  - ENTER_B: same rule applied to OpB. On the DIGITS-th digit, go to DONE, set Valid=1 and DigitCount=0.
  - Digit > 9 in ENTER_A or ENTER_B: digit discarded, BadDigit=1, operand, count and state unchanged.
  - DONE: a Press clears OpA, OpB and BadDigit, sets Valid=0 and returns to ENTER_A. Digit is ignored.
- Clear: same effect as Reset on OpA, OpB, Valid, Phase, DigitCount and BadDigit. The debounce state is kept, so a held button does not re-fire.
  - Clear and Press in the same cycle: Clear wins and the press is lost.
- Reset mid-entry: all state returns to reset values on that edge. A button still held after Reset releases must go low and high again to register.
- OpA and OpB are stable and unchanged in DONE. The downstream adder may sample them whenever Valid=1.

Optional Feature:
BCD_ENTRY_REPEAT_EN
- Defined: while the debounced level stays high in ENTER_A or ENTER_B, an extra Press is generated every REPEAT_CYCLES cycles after the initial Press. The repeat counter clears on release, on Clear and on Reset. No repeat presses are generated in DONE.
- Undefined: one Press per debounced rising edge only. REPEAT_CYCLES is unused and no repeat counter is synthesized.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, DIGITS=2, REPEAT_CYCLES=8.
- Entry sequence: Reset, then presses with Digit=4,7,1,9 -> OpA=8'h47 after the 2nd press, Phase 0->1, OpB=8'h19 after the 4th press, Phase=2, Valid=1. Each update lands 7 cycles after the raw Enter edge.
- Bounce rejection: Enter high for 3 cycles, low for 1, repeated 5 times, then held 10 cycles -> exactly one Press, DigitCount 0->1.
- Invalid digit: Digit=4'hC pressed in ENTER_A with OpA=8'h03 -> BadDigit=1, OpA=8'h03, DigitCount=1. Next press with Digit=5 -> OpA=8'h35, BadDigit=0.
- Restart and Clear: press in DONE -> OpA=OpB=0, Valid=0, Phase=0. Clear asserted in the Press cycle -> Press discarded, all outputs at reset values.
- Reset mid-entry: Reset after one OpB digit while Enter held high -> all reset values. No Press until Enter goes low and high again.
- Repeat on (macro defined): hold Enter for 30 cycles in ENTER_A with Digit=2 -> initial Press plus repeat presses every 8 cycles. After 2 presses OpA=8'h22 and Phase=1; later presses fill OpB=8'h22 and Phase=2; no further change in DONE.
